// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default timing constants and line levels.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd3,
      PARITY = 3'd4
   } uart_state_e;

   localparam int   NB_DATA_DEF      = 8;
   localparam int   CLKS_PER_BIT_DEF = 5208;
   localparam logic LINE_IDLE        = 1'b1;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and ticks in the last cycle of each bit.
// Held at zero while i_clear is high so every frame starts on a fresh bit boundary.
module baud_tick_gen #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   output logic o_tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d  = cnt_q;
      o_tick = (cnt_q == CNT_LAST) && !i_clear;
      if (i_clear || (cnt_q == CNT_LAST)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/alu_result_uart_tx.sv
// UART transmitter for the ALU result: start strobe loads a word, sent LSB-first as 8N1/8N2.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop bits.
//
// state  | meaning
// IDLE   | line high, waiting for i_tx_start
// START  | start bit (line low)
// DATA   | shifting data bits out LSB-first
// PARITY | even parity bit (UART_TX_PARITY_EN only)
// STOP   | NB_STOP stop bits, done pulses in the final cycle
module alu_result_uart_tx
   import uart_pkg::*;
#(
   parameter int NB_DATA      = NB_DATA_DEF,
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int NB_STOP      = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NB_DATA-1:0] i_data,
   input  logic               i_tx_start,
   output logic               o_tx,
   output logic               o_tx_busy,
   output logic               o_tx_done
);

   localparam int IDX_W = (NB_DATA > 2) ? $clog2(NB_DATA) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST_DATA = IDX_W'(NB_DATA - 1);
   localparam logic [IDX_W-1:0] IDX_LAST_STOP = IDX_W'(NB_STOP - 1);

   uart_state_e        state_q, state_d;
   logic [NB_DATA-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
   logic               tx_q, tx_d;
   logic               done;
   logic               tick;
`ifdef UART_TX_PARITY_EN
   logic               parity_q, parity_d;
`endif

   baud_tick_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_tick_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (state_q == IDLE),
      .o_tick  (tick)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      done      = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      case (state_q)
         IDLE: begin
            if (i_tx_start) begin
               state_d   = START;
               shift_d   = i_data;
               bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
               parity_d  = ^i_data;
`endif
            end
         end
         START: begin
            if (tick) begin
               state_d   = DATA;
               bit_idx_d = '0;
            end
         end
         DATA: begin
            if (tick) begin
               shift_d = shift_q >> 1;
               if (bit_idx_q == IDX_LAST_DATA) begin
                  bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d   = PARITY;
`else
                  state_d   = STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + IDX_W'(1);
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (tick) begin
               state_d   = STOP;
               bit_idx_d = '0;
            end
         end
`endif
         STOP: begin
            if (tick) begin
               if (bit_idx_q == IDX_LAST_STOP) begin
                  done      = 1'b1;
                  state_d   = IDLE;
                  bit_idx_d = '0;
               end else begin
                  bit_idx_d = bit_idx_q + IDX_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Line level is decided from the next state so o_tx changes on the same edge as the FSM.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_d = parity_q;
`endif
         default: tx_d = LINE_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_idx_q <= '0;
         tx_q      <= LINE_IDLE;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign o_tx      = tx_q;
   assign o_tx_busy = (state_q != IDLE);
   assign o_tx_done = done;

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Directed bench for alu_result_uart_tx at CLKS_PER_BIT=4, NB_STOP=1 with a line-level receiver model.
module tb_alu_result_uart_tx;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB_PAR = 1;
`else
   localparam int NB_PAR = 0;
`endif
   localparam int FRAME_BITS = 1 + 8 + NB_PAR + 1;
   localparam int FRAME_CYC  = FRAME_BITS * CPB;

   logic       clk        = 1'b0;
   logic       rst_n      = 1'b0;
   logic [7:0] i_data     = 8'h00;
   logic       i_tx_start = 1'b0;
   logic       o_tx;
   logic       o_tx_busy;
   logic       o_tx_done;

   int         n_checks = 0;
   int         n_pass   = 0;
   int         n_fail   = 0;
   logic [7:0] rx_q[$];

   alu_result_uart_tx #(
      .NB_DATA      (8),
      .CLKS_PER_BIT (CPB),
      .NB_STOP      (1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_data     (i_data),
      .i_tx_start (i_tx_start),
      .o_tx       (o_tx),
      .o_tx_busy  (o_tx_busy),
      .o_tx_done  (o_tx_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Strobe in cycle T; returns at the negedge of cycle T+1 with i_data scrambled.
   task automatic strobe(input logic [7:0] d);
      i_data     = d;
      i_tx_start = 1'b1;
      step();
      i_tx_start = 1'b0;
      i_data     = ~d;
   endtask

   // Walks cycles T+1..T+FRAME_CYC; optionally fires a stray strobe in cycle inject_at.
   task automatic expect_frame(input logic [7:0] d, input int inject_at);
      logic exp_tx;
      int   n;
      for (int b = 0; b < FRAME_BITS; b++) begin
         if (b == 0)                      exp_tx = 1'b0;
         else if (b <= 8)                 exp_tx = d[b-1];
         else if (b == 9 && NB_PAR == 1)  exp_tx = ^d;
         else                             exp_tx = 1'b1;
         for (int c = 0; c < CPB; c++) begin
            n = 1 + b * CPB + c;
            check($sformatf("tx_%02h_cyc%0d", d, n), o_tx, exp_tx);
            check($sformatf("busy_%02h_cyc%0d", d, n), o_tx_busy, 1);
            check($sformatf("done_%02h_cyc%0d", d, n), o_tx_done,
                  (b == FRAME_BITS - 1 && c == CPB - 1) ? 1 : 0);
            i_tx_start = (n == inject_at);
            if (n == inject_at) i_data = 8'hFF;
            step();
         end
      end
      i_tx_start = 1'b0;
      check($sformatf("end_busy_%02h", d), o_tx_busy, 0);
      check($sformatf("end_tx_%02h", d), o_tx, 1);
      check($sformatf("end_done_%02h", d), o_tx_done, 0);
   endtask

   task automatic idle_cycles(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_tx_%0d", tag, i), o_tx, 1);
         check($sformatf("%s_busy_%0d", tag, i), o_tx_busy, 0);
         check($sformatf("%s_done_%0d", tag, i), o_tx_done, 0);
         step();
      end
   endtask

   task automatic check_rx(input logic [7:0] exp);
      check($sformatf("rx_avail_%02h", exp), (rx_q.size() > 0) ? 1 : 0, 1);
      if (rx_q.size() > 0) check($sformatf("rx_byte_%02h", exp), rx_q.pop_front(), exp);
   endtask

   // Receiver model: samples mid-bit after a falling edge, keeps bytes with a valid stop bit.
   initial begin : rx_model
      logic       prev;
      logic [7:0] byte_r;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (prev === 1'b1 && o_tx === 1'b0 && rst_n === 1'b1) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               byte_r[i] = o_tx;
            end
            repeat (CPB * (1 + NB_PAR)) @(negedge clk);
            if (o_tx === 1'b1) rx_q.push_back(byte_r);
         end
         prev = o_tx;
      end
   end

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx", o_tx, 1);
      check("rst_busy", o_tx_busy, 0);
      check("rst_done", o_tx_done, 0);
      rst_n = 1'b1;
      idle_cycles("idle_after_rst", 8);

      strobe(8'hA5);
      expect_frame(8'hA5, 0);
      check_rx(8'hA5);

      strobe(8'h3C);
      expect_frame(8'h3C, 10);
      idle_cycles("no_queue_mid", 6);
      check_rx(8'h3C);
      check("rx_empty_after_3c", rx_q.size(), 0);

      strobe(8'h5A);
      expect_frame(8'h5A, FRAME_CYC);
      idle_cycles("no_queue_done", 6);
      check_rx(8'h5A);
      check("rx_empty_after_5a", rx_q.size(), 0);

      strobe(8'h01);
      expect_frame(8'h01, 0);
      strobe(8'h80);
      expect_frame(8'h80, 0);
      idle_cycles("after_b2b", 4);
      check_rx(8'h01);
      check_rx(8'h80);

      strobe(8'hC3);
      repeat (17) step();
      check("mid_bit3_tx", o_tx, 0);
      check("mid_bit3_busy", o_tx_busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_tx", o_tx, 1);
      check("async_rst_busy", o_tx_busy, 0);
      check("async_rst_done", o_tx_done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle_cycles("after_abort", 40);
      rx_q.delete();
      strobe(8'h55);
      expect_frame(8'h55, 0);
      check_rx(8'h55);

`ifdef UART_TX_PARITY_EN
      strobe(8'h07);
      expect_frame(8'h07, 0);
      check_rx(8'h07);
      strobe(8'h03);
      expect_frame(8'h03, 0);
      check_rx(8'h03);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
